encoder_serial_n: RTL
=====================

# encoder_serial_n

Parametrised, sequential successor to the 4-to-2 encoder. It accepts an N-bit multi-hot request vector over a valid/ready handshake and emits the binary index of every set bit, one per output beat, highest index first. An all-zero vector produces a single "none" beat. It sits between request-collection logic and any downstream consumer that handles one encoded index at a time.

## Interface
- `N`, default 8: input vector width; power of two, 2..64.
- `W`, default `$clog2(N)` (3): index width; derived, never overridden.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `i` holds a vector to encode.
- `in_ready` output 1: block can accept a vector.
- `i` input N: request vector; bit k maps to index k.
- `out_valid` output 1: `o`, `o_none`, `o_last` are valid.
- `out_ready` input 1: consumer accepts the current beat.
- `o` output W: index of the current set bit.
- `o_none` output 1: accepted vector was all-zero.
- `o_last` output 1: final beat for this vector.
- `cnt` output W+1: population count of the accepted vector. Present only with the macro.

## Operation
- FSM has two states, IDLE and EMIT.
- IDLE: `in_ready`=1 and `out_valid`=0. On `in_valid && in_ready`, `i` is latched into the internal `pend` register and the state goes to EMIT.
- EMIT: `out_valid`=1 and `in_ready`=0.
  - `o` = highest set index in `pend`.
  - `o_last`=1 when `pend` has exactly one bit set, or `pend`==0.
  - `o_none`=1 only when `pend`==0; `o` is then 0 and `o_last` is 1.
- Beat transfer happens on `out_valid && out_ready`:
  - The bit at `o` is cleared in `pend`.
  - If `o_last`=1, the state returns to IDLE.
- Back-pressure: while `out_valid && !out_ready`, `o`, `o_none`, `o_last` and `cnt` hold stable.
- `i` is ignored outside the accept cycle; later changes to `i` do not affect the vector in flight.
- `o`, `o_none` and `o_last` are decoded combinationally from the registered `pend`; there is no input-to-output combinational path.

## Timing
- Reset values: state=IDLE, `pend`=0, `out_valid`=0, `o`=0, `o_none`=0, `o_last`=0, `cnt`=0.
- `in_ready` is forced to 0 while `rst`=1, and is 1 in the first cycle after `rst` deasserts.
- Latency: a vector accepted at edge t has its first beat valid in cycle t+1.
- A vector with k>0 set bits takes k beats; an all-zero vector takes 1 beat.
- After the last beat transfers at edge t, `in_ready`=1 in cycle t+1. There is no same-cycle accept-and-emit, so the minimum period is beats+1 cycles.
- `rst` asserted mid-EMIT drops the vector without completing it. The state goes to IDLE on that edge, no further beats are emitted, and `pend` is cleared.
- If `in_valid` is asserted during EMIT it is not accepted; the producer holds the vector until `in_ready` returns.
- N=2 (W=1) is supported; bit 1 is emitted before bit 0.

## Configuration
- `ENCODER_SERIAL_COUNT_EN` defined:
  - The `cnt` port exists.
  - On acceptance, `cnt` is registered to popcount(`i`), from 0 to N inclusive.
  - `cnt` holds through all beats of that vector, then holds until the next acceptance.
- Not defined: the `cnt` port and the popcount logic are absent; all other behaviour is identical.

## Test plan
- Reset, then `i`=8'b0000_0000 with `in_valid`=1 → one beat: `o`=0, `o_none`=1, `o_last`=1; `cnt`=0 with the macro.
- `i`=8'b1010_0101 with `out_ready` held at 1 → beats `o`=7, 5, 2, 0 in consecutive cycles; `o_last` is 1 only on `o`=0; `cnt`=4; `in_ready`=1 the following cycle.
- `i`=8'b1000_0001 with `out_ready` low for 3 cycles on the first beat → `o`=7 held stable for 4 cycles, then `o`=0 with `o_last`=1.
- Accept 8'b1111_1111, then assert `rst` after the third beat → next cycle `out_valid`=0, `in_ready`=1, and no further beats appear.
- Change `i` to 8'b0000_0010 during EMIT of 8'b0100_0000 → single beat `o`=6 with `o_last`=1; the new vector is accepted only once IDLE is re-entered.
- Sweep all 16 vectors with N=4 → the beat sequence matches the descending set-bit indices of each vector, with `o_none`=1 only for 4'b0000.

Source files
------------

// File: rtl/encoder_serial_n.sv
// rtl/encoder_serial_n.sv - serial multi-hot encoder, one set-bit index per beat, highest first
// Optional popcount output on cnt when ENCODER_SERIAL_COUNT_EN is defined.
module encoder_serial_n #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] o,
  output logic         o_none,
  output logic         o_last
`ifdef ENCODER_SERIAL_COUNT_EN
  ,
  output logic [W:0]   cnt
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] clr_mask;
  logic [W-1:0] top_idx;
  logic         pend_zero;
  logic         pend_one;
  logic         emit;

  // Priority scan: later (higher) set bits overwrite earlier ones.
  always_comb begin
    top_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (pend_q[k]) top_idx = W'(k);
    end
  end

  assign pend_zero = (pend_q == '0);
  assign pend_one  = !pend_zero && ((pend_q & (pend_q - N'(1))) == '0);
  assign emit      = (state_q == EMIT);

  assign out_valid = emit;
  assign in_ready  = (state_q == IDLE) && !rst;
  assign o         = emit ? top_idx : '0;
  assign o_none    = emit && pend_zero;
  assign o_last    = emit && (pend_zero || pend_one);

  always_comb begin
    state_d           = state_q;
    pend_d            = pend_q;
    clr_mask          = '0;
    clr_mask[top_idx] = 1'b1;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pend_d  = i;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_d = pend_q & ~clr_mask;
          if (o_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ENCODER_SERIAL_COUNT_EN
  logic [W:0] cnt_q, cnt_d;
  logic [W:0] pop;

  always_comb begin
    pop = '0;
    for (int k = 0; k < N; k++) begin
      pop = pop + (W+1)'(i[k]);
    end
    cnt_d = cnt_q;
    if (state_q == IDLE && in_valid) cnt_d = pop;
  end

  assign cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule
